// File: rtl/window_actuator.sv
// Window motor controller: turns open/close command pulses into motor drive,
// supervising travel with limit switches, a travel timeout, auto-close dwell and a latched fault.
module window_actuator #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned HOLD    = 32,
  parameter int unsigned CW      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic open_cmd,
  input  logic close_cmd,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic fault_clear,
  output logic motor_open,
  output logic motor_close,
  output logic window_open,
  output logic busy,
  output logic fault
);

  typedef enum logic [2:0] {
    S_CLOSED,
    S_OPENING,
    S_OPEN,
    S_CLOSING,
    S_FAULT
  } state_t;

  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam bit            HOLD_EN   = (HOLD != 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          motor_open_q, motor_close_q, window_open_q, busy_q, fault_q;

  // Next-state and dwell/travel counter; counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    unique case (state_q)
      S_CLOSED: begin
        if (open_cmd) state_d = S_OPENING;
      end
      S_OPENING: begin
        if (limit_open && limit_closed) state_d = S_FAULT;
        else if (limit_open)            state_d = S_OPEN;
        else if (close_cmd)             state_d = S_CLOSING;
        else if (cnt_q == TO_LAST)      state_d = S_FAULT;
      end
      S_OPEN: begin
        if (close_cmd)                           state_d = S_CLOSING;
        else if (open_cmd)                       cnt_d   = '0;
        else if (HOLD_EN && cnt_q == HOLD_LAST)  state_d = S_CLOSING;
      end
      S_CLOSING: begin
        if (limit_open && limit_closed) state_d = S_FAULT;
        else if (limit_closed)          state_d = S_CLOSED;
        else if (open_cmd)              state_d = S_OPENING;
        else if (cnt_q == TO_LAST)      state_d = S_FAULT;
      end
      S_FAULT: begin
        if (fault_clear) state_d = S_CLOSING;
      end
      default: state_d = S_CLOSED;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counter and Moore outputs decoded from the next state so they track it edge-for-edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_CLOSED;
      cnt_q         <= '0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      window_open_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      motor_open_q  <= (state_d == S_OPENING);
      motor_close_q <= (state_d == S_CLOSING);
      window_open_q <= (state_d == S_OPEN);
      busy_q        <= (state_d == S_OPENING) || (state_d == S_CLOSING);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign motor_open  = motor_open_q;
  assign motor_close = motor_close_q;
  assign window_open = window_open_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_window_actuator.sv
// Directed bench for window_actuator (TIMEOUT=16, HOLD=32) with hand-computed expectations.
module tb_window_actuator;

  logic clock = 1'b0;
  logic reset, open_cmd, close_cmd, limit_open, limit_closed, fault_clear;
  logic motor_open, motor_close, window_open, busy, fault;
  logic [4:0] outs;

  // Output vector encoding {motor_open, motor_close, window_open, busy, fault}
  localparam logic [4:0] O_CLOSED  = 5'b00000;
  localparam logic [4:0] O_OPENING = 5'b10010;
  localparam logic [4:0] O_OPEN    = 5'b00100;
  localparam logic [4:0] O_CLOSING = 5'b01010;
  localparam logic [4:0] O_FAULT   = 5'b00001;

  int n_cmp = 0;
  int n_err = 0;

  window_actuator #(.TIMEOUT(16), .HOLD(32), .CW(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .open_cmd     (open_cmd),
    .close_cmd    (close_cmd),
    .limit_open   (limit_open),
    .limit_closed (limit_closed),
    .fault_clear  (fault_clear),
    .motor_open   (motor_open),
    .motor_close  (motor_close),
    .window_open  (window_open),
    .busy         (busy),
    .fault        (fault)
  );

  assign outs = {motor_open, motor_close, window_open, busy, fault};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_open();
    open_cmd = 1'b1; step(); open_cmd = 1'b0;
  endtask

  task automatic pulse_close();
    close_cmd = 1'b1; step(); close_cmd = 1'b0;
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1; step(); fault_clear = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return motor_open;
      1:       return motor_close;
      default: return window_open;
    endcase
  endfunction

  // Counts consecutive cycles a signal stays high, starting from a cycle already seen high.
  task automatic count_high(input int which, output int n);
    n = 1;
    while (sig(which) && n < 200) begin
      step();
      if (sig(which)) n++;
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; open_cmd = 1'b0; close_cmd = 1'b0;
    limit_open = 1'b0; limit_closed = 1'b0; fault_clear = 1'b0;
    repeat (2) step();
    check("reset_outs", 32'(outs), 32'(O_CLOSED));
    reset = 1'b0;

    // CLOSED ignores close_cmd and limits
    limit_open = 1'b1; pulse_close(); limit_open = 1'b0;
    check("closed_ignore", 32'(outs), 32'(O_CLOSED));

    // Normal cycle
    pulse_open();
    check("t1_opening", 32'(outs), 32'(O_OPENING));
    repeat (4) step();
    limit_open = 1'b1; step(); limit_open = 1'b0;
    check("t1_open", 32'(outs), 32'(O_OPEN));
    count_high(2, n);
    check("t1_hold_len", 32'(n), 32'd32);
    check("t1_autoclose", 32'(outs), 32'(O_CLOSING));
    limit_closed = 1'b1; step(); limit_closed = 1'b0;
    check("t1_closed", 32'(outs), 32'(O_CLOSED));

    // Timeout and re-home
    pulse_open();
    count_high(0, n);
    check("t2_open_len", 32'(n), 32'd16);
    check("t2_fault", 32'(outs), 32'(O_FAULT));
    pulse_clear();
    check("t2_rehome", 32'(outs), 32'(O_CLOSING));
    count_high(1, n);
    check("t2_rehome_len", 32'(n), 32'd16);
    check("t2_rehome_to", 32'(outs), 32'(O_FAULT));
    // Limit already asserted on the entry edge: one-cycle travel
    limit_closed = 1'b1; pulse_clear();
    check("t2_entry_lim", 32'(outs), 32'(O_CLOSING));
    step(); limit_closed = 1'b0;
    check("t2_closed", 32'(outs), 32'(O_CLOSED));

    // Reversal both ways
    pulse_open();
    repeat (2) step();
    pulse_close();
    check("t3_rev_close", 32'(outs), 32'(O_CLOSING));
    step();
    pulse_open();
    check("t3_rev_open", 32'(outs), 32'(O_OPENING));
    limit_open = 1'b1; step(); limit_open = 1'b0;
    pulse_close();
    limit_closed = 1'b1; step(); limit_closed = 1'b0;
    check("t3_closed", 32'(outs), 32'(O_CLOSED));

    // Dwell restart
    pulse_open();
    limit_open = 1'b1; step(); limit_open = 1'b0;
    repeat (19) step();
    check("t4_pre_pulse", 32'(outs), 32'(O_OPEN));
    pulse_open();
    count_high(2, n);
    check("t4_after_len", 32'(n), 32'd32);
    check("t4_total_len", 32'(20 + n), 32'd52);
    check("t4_autoclose", 32'(outs), 32'(O_CLOSING));
    pulse_open();
    limit_open = 1'b1; step(); limit_open = 1'b0;
    repeat (31) step();
    pulse_open();
    check("t4_expiry_win", 32'(outs), 32'(O_OPEN));
    open_cmd = 1'b1; close_cmd = 1'b1; step(); open_cmd = 1'b0; close_cmd = 1'b0;
    check("t4_both_cmds", 32'(outs), 32'(O_CLOSING));
    limit_closed = 1'b1; step(); limit_closed = 1'b0;

    // Sensor conflict
    pulse_open();
    limit_open = 1'b1; limit_closed = 1'b1; step(); limit_open = 1'b0; limit_closed = 1'b0;
    check("t5_conflict", 32'(outs), 32'(O_FAULT));
    pulse_close();
    pulse_open();
    limit_closed = 1'b1; step(); limit_closed = 1'b0;
    check("t5_fault_held", 32'(outs), 32'(O_FAULT));
    pulse_clear();
    limit_closed = 1'b1; step(); limit_closed = 1'b0;
    check("t5_recovered", 32'(outs), 32'(O_CLOSED));

    // Async reset mid-travel
    pulse_open();
    repeat (6) step();
    check("t6_pre_reset", 32'(outs), 32'(O_OPENING));
    #2 reset = 1'b1;
    #1 check("t6_async_rst", 32'(outs), 32'(O_CLOSED));
    step(); reset = 1'b0;
    pulse_close();
    check("t6_closed_ign", 32'(outs), 32'(O_CLOSED));
    pulse_open();
    count_high(0, n);
    check("t6_fresh_to", 32'(n), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
